keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_debounce.sv | 44 ++++
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - kp_state_e : scanner FSM states
//   - KP_ROWS / KP_COLS / KP_CODE_W : matrix geometry and key code width
//   - kp_code()      : forms the key code {row_idx, col_idx}
//   - kp_oh2idx()    : one-hot row vector to row index
//   - kp_is_onehot() : true when exactly one bit of a row sample is set
package keypad_pkg;

    localparam int KP_ROWS   = 4;
    localparam int KP_COLS   = 4;
    localparam int KP_CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    function automatic logic [KP_CODE_W-1:0] kp_code(input logic [1:0] row_idx,
                                                     input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

    function automatic logic [1:0] kp_oh2idx(input logic [KP_ROWS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < KP_ROWS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic kp_is_onehot(input logic [KP_ROWS-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive cycles in which 'match' is high.
// Shared by the press (DEBOUNCE) and release (RELEASE) phases of the scanner.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset
//   match in  current sample agrees with the wanted level
//   clear in  force the count back to zero
//   done  out combinational: this cycle is the CYCLES-th consecutive match
module keypad_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic match,
    input  logic clear,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] FULL = CW'(CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at CYCLES so a held level can never wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !match) begin
            cnt_d = '0;
        end else if (cnt_q != FULL) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Fires on the match cycle that completes the run, so the FSM can leave
    // the phase on the very next edge.
    assign done = match && !clear && (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces press and release,
// and emits one single-cycle din/din_valid code per physical keypress.
// Key code is {row_idx, col_idx}.
// Ports:
//   clk        in  clock
//   reset      in  synchronous active-high reset
//   row_sense  in  [3:0] row return lines, active-high
//   col_drive  out [3:0] one-hot column drive, active-high
//   din        out [3:0] key code, qualify with din_valid
//   din_valid  out one-cycle pulse per accepted keypress
//   ghost_err  out one-cycle pulse when a scan sample shows >1 row high
// Configuration macro: KEYPAD_SYNC_EN -- when defined, row_sense goes through
// a 2-flop synchronizer and each column dwell grows by 2 cycles.
// Handshake: din_valid is a pure one-cycle strobe with no ready/back-pressure;
// din is meaningful only in the cycle din_valid is high and holds afterwards.
// Debug: state_dbg carries the current FSM state for checkers.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KP_ROWS-1:0]   row_sense,
    output logic [KP_COLS-1:0]   col_drive,
    output logic [KP_CODE_W-1:0] din,
    output logic                 din_valid,
    output logic                 ghost_err
);

    logic [KP_ROWS-1:0] row_s;

`ifdef KEYPAD_SYNC_EN
    // Two extra dwell cycles let the synchronizer catch up with a column change.
    localparam int DWELL = SCAN_CYCLES + 2;
    logic [KP_ROWS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= row_sense;
            sync2_q <= sync1_q;
        end
    end
    assign row_s = sync2_q;
`else
    localparam int DWELL = SCAN_CYCLES;
    assign row_s = row_sense;
`endif

    localparam int DW_W = $clog2(DWELL);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    kp_state_e                state_q, state_d;
    logic [1:0]               col_q, col_d;
    logic [DW_W-1:0]          dwell_q, dwell_d;
    logic [KP_ROWS-1:0]       row_oh_q, row_oh_d;
    logic [KP_CODE_W-1:0]     din_q, din_d;
    logic                     valid_q, valid_d;
    logic                     ghost_q, ghost_d;
    logic                     db_match, db_clear, db_done;
    kp_state_e                state_dbg;

    assign state_dbg = state_q;

    // Counter only runs in the two phases that need it; elsewhere it is held
    // at zero so each phase starts from a fresh count.
    assign db_clear = (state_q != DEBOUNCE) && (state_q != RELEASE);

    keypad_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .match (db_match),
        .clear (db_clear),
        .done  (db_done)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        dwell_d  = dwell_q;
        row_oh_d = row_oh_q;
        din_d    = din_q;
        valid_d  = 1'b0;
        ghost_d  = 1'b0;
        db_match = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row_s == '0) begin
                        col_d = col_q + 2'd1;
                    end else if (kp_is_onehot(row_s)) begin
                        // Hold this column; row is remembered for debounce.
                        row_oh_d = row_s;
                        state_d  = DEBOUNCE;
                    end else begin
                        ghost_d = 1'b1;
                        col_d   = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            DEBOUNCE: begin
                db_match = (row_s == row_oh_q);
                if (!db_match) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else if (db_done) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                din_d   = kp_code(kp_oh2idx(row_oh_q), col_q);
                valid_d = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                db_match = (row_s == '0);
                if (db_done) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SCAN;
            col_q    <= 2'd0;
            dwell_q  <= '0;
            row_oh_q <= '0;
            din_q    <= '0;
            valid_q  <= 1'b0;
            ghost_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            dwell_q  <= dwell_d;
            row_oh_q <= row_oh_d;
            din_q    <= din_d;
            valid_q  <= valid_d;
            ghost_q  <= ghost_d;
        end
    end

    // Decoded from a 2-bit index, so the drive is one-hot by construction.
    assign col_drive = 4'b0001 << col_q;
    assign din       = din_q;
    assign din_valid = valid_q;
    assign ghost_err = ghost_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DB = 8;
    localparam int WORST_LAT = 4 * SC + DB + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_sense;
    logic [3:0]  col_drive;
    logic [3:0]  din;
    logic        din_valid;
    logic        ghost_err;

    // Physical key matrix: bit r*4+c is the key at (row r, column c).
    logic [15:0] keys = '0;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_sense (row_sense),
        .col_drive (col_drive),
        .din       (din),
        .din_valid (din_valid),
        .ghost_err (ghost_err)
    );

    // Keypad emulation: a row line is high when a pressed key sits on a driven column.
    always_comb begin
        row_sense = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_drive[c] && keys[r*4+c]) row_sense[r] = 1'b1;
            end
        end
    end

    // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        keys  = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (col_drive !== 4'b0001 || din !== 4'h0 || din_valid !== 1'b0 || ghost_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_values col=%b din=%h dv=%b ge=%b want col=0001 din=0 dv=0 ge=0",
                         col_drive, din, din_valid, ghost_err);
            end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] exp_col;
        keys = '0;
        do_reset();
        for (int cy = 0; cy < 8 * SC; cy++) begin
            exp_col = 4'b0001 << ((cy / SC) % 4);
            checks++;
            if (col_drive !== exp_col || din_valid !== 1'b0) begin
                errors++;
                $display("FAIL sweep cycle=%0d col=%b dv=%b want col=%b dv=0", cy, col_drive, din_valid, exp_col);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        int pulses;
        int exp_cy;
        keys = 16'(1) << (0 * 4 + 1);
        do_reset();
        exp_cy = 1 * SC + (SC - 1) + DB + 2;
        pulses = 0;
        for (int cy = 0; cy < 300; cy++) begin
            if (din_valid === 1'b1) pulses++;
            if (cy == exp_cy) begin
                checks++;
                if (din_valid !== 1'b1 || din !== 4'h1) begin
                    errors++;
                    $display("FAIL hold_pulse cycle=%0d dv=%b din=%h want dv=1 din=1", cy, din_valid, din);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL hold_count pulses=%0d want 1", pulses);
        end
        keys = '0;
        pulses = 0;
        for (int cy = 0; cy < 40; cy++) begin
            if (din_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0 || din !== 4'h1) begin
            errors++;
            $display("FAIL hold_release pulses=%0d din=%h want 0 pulses din=1", pulses, din);
        end
    endtask

    task automatic test_bounce();
        int bad;
        keys = '0;
        do_reset();
        bad = 0;
        for (int cy = 0; cy < 70; cy++) begin
            // Row line toggles every 3 cycles; high when the column-2 sample lands at cycle 11.
            if (cy < 30) keys[1*4+2] = (((cy + 1) / 3) % 2 == 0);
            else         keys = '0;
            if (din_valid !== 1'b0 || ghost_err !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_ghost();
        logic exp_g;
        keys = '0;
        keys[1*4+0] = 1'b1;
        keys[2*4+0] = 1'b1;
        do_reset();
        for (int cy = 0; cy < 64; cy++) begin
            // Column 0 is sampled at cycle 3 of every 16-cycle sweep.
            exp_g = ((cy % (4 * SC)) == SC);
            checks++;
            if (ghost_err !== exp_g || din_valid !== 1'b0) begin
                errors++;
                $display("FAIL ghost cycle=%0d ge=%b dv=%b want ge=%b dv=0", cy, ghost_err, din_valid, exp_g);
            end
            @(negedge clk);
        end
        keys = '0;
    endtask

    task automatic test_reset_mid();
        int rst_cy;
        int found;
        keys = 16'(1) << (2 * 4 + 3);
        do_reset();
        // Column 3 sampled at 4*SC-1; count reaches 5 after the fifth debounce cycle.
        rst_cy = (4 * SC - 1) + 5 + 1;
        for (int cy = 0; cy < rst_cy; cy++) begin
            checks++;
            if (din_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_early cycle=%0d dv=%b want 0", cy, din_valid);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        keys  = '0;
        @(negedge clk);
        checks++;
        if (col_drive !== 4'b0001 || din_valid !== 1'b0 || din !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_after col=%b dv=%b din=%h want col=0001 dv=0 din=0", col_drive, din_valid, din);
        end
        repeat (DB + 4) begin
            @(negedge clk);
            checks++;
            if (din_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet dv=%b want 0", din_valid);
            end
        end
        keys = 16'(1) << (2 * 4 + 3);
        do_reset();
        found = -1;
        for (int cy = 0; cy < WORST_LAT + 8; cy++) begin
            if (din_valid === 1'b1 && found < 0) begin
                found = cy;
                checks++;
                if (din !== 4'hb) begin
                    errors++;
                    $display("FAIL fresh_press_code din=%h want b", din);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (found != (4 * SC - 1) + DB + 2) begin
            errors++;
            $display("FAIL fresh_press_time cycle=%0d want %0d", found, (4 * SC - 1) + DB + 2);
        end
        keys = '0;
        repeat (DB + 4 * SC) @(negedge clk);
    endtask

    // One physical press: model expects exactly one code r*4+c within the worst-case latency.
    task automatic press_key(input int r, input int c, input int hold, input int gap);
        int pulses;
        logic [3:0] e;
        exp_q.push_back(4'(r * 4 + c));
        keys = 16'(1) << (r * 4 + c);
        pulses = 0;
        for (int i = 0; i < hold + gap; i++) begin
            @(negedge clk);
            if (i == hold) keys = '0;
            checks++;
            if (ghost_err !== 1'b0) begin
                errors++;
                $display("FAIL press_ghost key=(%0d,%0d) ge=%b want 0", r, c, ghost_err);
            end
            if (din_valid === 1'b1) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL press_extra key=(%0d,%0d) din=%h want no pulse", r, c, din);
                end else begin
                    e = exp_q.pop_front();
                    if (din !== e) begin
                        errors++;
                        $display("FAIL press_code key=(%0d,%0d) din=%h want %h", r, c, din, e);
                    end
                end
                checks++;
                if (i + 1 > WORST_LAT) begin
                    errors++;
                    $display("FAIL press_latency key=(%0d,%0d) lat=%0d want <=%0d", r, c, i + 1, WORST_LAT);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || pulses != 1) begin
            errors++;
            $display("FAIL press_count key=(%0d,%0d) pulses=%0d want 1", r, c, pulses);
        end
        exp_q.delete();
    endtask

    task automatic test_sequence();
        keys = '0;
        do_reset();
        press_key(3, 0, 40, 40);
        press_key(0, 0, 40, 40);
        press_key(3, 1, 40, 40);
        press_key(3, 2, 40, 40);
    endtask

    task automatic test_random();
        keys = '0;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            press_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(40, 80)), int'($urandom_range(30, 60)));
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_hold();
        test_bounce();
        test_ghost();
        test_reset_mid();
        test_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
